// File: rtl/gen_speed_switch_ctrl.sv
// Sequences gen_speed changes: quiesce datapath, reset divider, apply new speed, settle, release.
// All outputs registered; requests handshake on speed_req_valid/speed_req_ready and are dropped while not ready.
module gen_speed_switch_ctrl #(
  parameter int         RST_CYCLES    = 4,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter logic [1:0] RESET_SPEED   = 2'b00
) (
  input  logic       local_clk,
  input  logic       rst,
  input  logic       speed_req_valid,
  input  logic [1:0] speed_req,
  output logic       speed_req_ready,
  input  logic       datapath_idle,
  output logic       datapath_hold,
  output logic [1:0] gen_speed,
  output logic       div_rst_n,
  output logic       clk_stable,
  output logic       change_done,
  output logic       change_err
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    DRAIN  = 3'd2,
    RESET  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  target, target_nxt;
  logic [1:0]  gen_speed_nxt;
  logic        via_chg, via_chg_nxt;
  logic        done_nxt, err_nxt;
  logic        ready_nxt, hold_nxt, div_rst_n_nxt, clk_stable_nxt;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 16'd1;
    target_nxt    = target;
    gen_speed_nxt = gen_speed;
    via_chg_nxt   = via_chg;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      INIT: begin
        if (cnt == RST_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (speed_req_valid && speed_req_ready) begin
          if (speed_req == 2'b11) begin
            err_nxt = 1'b1;
          end else if (speed_req == gen_speed) begin
            done_nxt = 1'b1;
          end else begin
            target_nxt = speed_req;
            state_nxt  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // idle on the final timeout cycle still wins over the abort
        if (datapath_idle) begin
          state_nxt     = RESET;
          cnt_nxt       = '0;
          gen_speed_nxt = target;
          via_chg_nxt   = 1'b1;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          done_nxt  = via_chg;
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        via_chg_nxt = 1'b0;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ready_nxt      = (state_nxt == IDLE);
    hold_nxt       = (state_nxt != IDLE);
    div_rst_n_nxt  = !((state_nxt == INIT) || (state_nxt == RESET));
    clk_stable_nxt = (state_nxt == IDLE) || (state_nxt == DRAIN) || (state_nxt == DONE);
  end

  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state           <= INIT;
      cnt             <= '0;
      target          <= RESET_SPEED;
      via_chg         <= 1'b0;
      gen_speed       <= RESET_SPEED;
      div_rst_n       <= 1'b0;
      datapath_hold   <= 1'b1;
      clk_stable      <= 1'b0;
      speed_req_ready <= 1'b0;
      change_done     <= 1'b0;
      change_err      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      target          <= target_nxt;
      via_chg         <= via_chg_nxt;
      gen_speed       <= gen_speed_nxt;
      div_rst_n       <= div_rst_n_nxt;
      datapath_hold   <= hold_nxt;
      clk_stable      <= clk_stable_nxt;
      speed_req_ready <= ready_nxt;
      change_done     <= done_nxt;
      change_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_gen_speed_switch_ctrl.sv
// Directed bench for gen_speed_switch_ctrl with default parameters.
module tb_gen_speed_switch_ctrl;

  logic       local_clk = 1'b0;
  logic       rst = 1'b0;
  logic       speed_req_valid = 1'b0;
  logic [1:0] speed_req = 2'b00;
  logic       speed_req_ready;
  logic       datapath_idle = 1'b0;
  logic       datapath_hold;
  logic [1:0] gen_speed;
  logic       div_rst_n;
  logic       clk_stable;
  logic       change_done;
  logic       change_err;

  int n_chk = 0;
  int n_pass = 0;
  logic dn_seen;

  gen_speed_switch_ctrl dut (
    .local_clk       (local_clk),
    .rst             (rst),
    .speed_req_valid (speed_req_valid),
    .speed_req       (speed_req),
    .speed_req_ready (speed_req_ready),
    .datapath_idle   (datapath_idle),
    .datapath_hold   (datapath_hold),
    .gen_speed       (gen_speed),
    .div_rst_n       (div_rst_n),
    .clk_stable      (clk_stable),
    .change_done     (change_done),
    .change_err      (change_err)
  );

  always #5 local_clk = ~local_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge local_clk);
    #1;
  endtask

  initial begin
    tick(2);
    chk("rst_div_rst_n", div_rst_n, 0);
    chk("rst_hold", datapath_hold, 1);
    chk("rst_ready", speed_req_ready, 0);
    chk("rst_clk_stable", clk_stable, 0);
    chk("rst_gen_speed", gen_speed, 0);
    chk("rst_done_err", {change_done, change_err}, 0);

    // bring-up: cycle 1 is the interval right after release
    rst = 1'b1;
    dn_seen = 1'b0;
    for (int c = 1; c <= 262; c++) begin
      if (c > 1) tick();
      dn_seen |= change_done;
      if (c == 4) chk("bu_div_rst_c4", div_rst_n, 0);
      if (c == 5) chk("bu_div_rst_c5", div_rst_n, 1);
      if (c == 260) chk("bu_stable_c260", clk_stable, 0);
      if (c == 261) begin
        chk("bu_stable_c261", clk_stable, 1);
        chk("bu_ready_c261", speed_req_ready, 0);
      end
      if (c == 262) chk("bu_ready_c262", speed_req_ready, 1);
    end
    chk("bu_no_done", dn_seen, 0);
    chk("bu_gen_speed", gen_speed, 0);

    // change 00 -> 10 with datapath already idle
    datapath_idle = 1'b1;
    speed_req = 2'b10;
    speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    chk("chg_t1_hold", datapath_hold, 1);
    chk("chg_t1_ready", speed_req_ready, 0);
    chk("chg_t1_gen", gen_speed, 0);
    tick();
    chk("chg_t2_divrst", div_rst_n, 0);
    chk("chg_t2_gen", gen_speed, 2);
    chk("chg_t2_stable", clk_stable, 0);
    tick(3);
    chk("chg_t5_divrst", div_rst_n, 0);
    tick();
    chk("chg_t6_divrst", div_rst_n, 1);
    chk("chg_t6_stable", clk_stable, 0);
    tick(255);
    chk("chg_t261_stable", clk_stable, 0);
    tick();
    chk("chg_t262_stable", clk_stable, 1);
    chk("chg_t262_done", change_done, 1);
    chk("chg_t262_hold", datapath_hold, 1);
    tick();
    chk("chg_t263_ready", speed_req_ready, 1);
    chk("chg_t263_done", change_done, 0);
    chk("chg_t263_hold", datapath_hold, 0);

    // same-speed request is a no-op completion
    speed_req = 2'b10;
    speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    chk("same_done", change_done, 1);
    chk("same_err", change_err, 0);
    chk("same_divrst", div_rst_n, 1);
    chk("same_hold", datapath_hold, 0);
    tick();
    chk("same_done_off", change_done, 0);

    // illegal speed
    speed_req = 2'b11;
    speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    chk("ill_err", change_err, 1);
    chk("ill_done", change_done, 0);
    chk("ill_gen", gen_speed, 2);
    chk("ill_ready", speed_req_ready, 1);
    tick();
    chk("ill_err_off", change_err, 0);

    // drain timeout
    datapath_idle = 1'b0;
    speed_req = 2'b01;
    speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    chk("to_d1_hold", datapath_hold, 1);
    tick(1023);
    chk("to_d1024_hold", datapath_hold, 1);
    chk("to_d1024_err", change_err, 0);
    tick();
    chk("to_err", change_err, 1);
    chk("to_hold", datapath_hold, 0);
    chk("to_gen", gen_speed, 2);
    chk("to_ready", speed_req_ready, 1);
    tick();
    chk("to_err_off", change_err, 0);

    // idle arriving on the last drain cycle still proceeds
    speed_req = 2'b01;
    speed_req_valid = 1'b1;
    tick();
    speed_req_valid = 1'b0;
    tick(1023);
    datapath_idle = 1'b1;
    tick();
    chk("edge_divrst", div_rst_n, 0);
    chk("edge_gen", gen_speed, 1);
    chk("edge_err", change_err, 0);

    // reset in the middle of RESET aborts the change
    tick();
    rst = 1'b0;
    #1;
    chk("abort_gen", gen_speed, 0);
    chk("abort_divrst", div_rst_n, 0);
    chk("abort_hold", datapath_hold, 1);
    chk("abort_ready", speed_req_ready, 0);
    chk("abort_stable", clk_stable, 0);
    tick(2);
    rst = 1'b1;
    dn_seen = 1'b0;
    for (int c = 2; c <= 262; c++) begin
      tick();
      dn_seen |= change_done;
      if (c == 261) chk("rebu_ready_c261", speed_req_ready, 0);
    end
    chk("rebu_ready", speed_req_ready, 1);
    chk("rebu_gen", gen_speed, 0);
    chk("rebu_no_done", dn_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
